itag_assoc: RTL and testbench

Parametrised set-associative instruction-cache tag array for the ICU. Generalises the single-way tag store to WAYS ways × SETS sets. Each way holds a TAG_W-bit tag and a valid bit, stored in flops, and the block adds:
- registered hit/way lookup;
- internal victim selection on fill;
- a one-set-per-cycle invalidate sweep;
- a built-in march self-test that drives `itag_test_err_l`.

---
 rtl/itag_assoc_pkg.sv | 31 +++
 rtl/itag_assoc_ctl.sv | 99 +++++++++
 rtl/itag_assoc.sv | 142 ++++++++++++++
 tb/tb_itag_assoc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/itag_assoc_pkg.sv
// Shared definitions for the set-associative instruction tag array:
// controller state encoding, BIST fill patterns and phase sequencing.
package itag_assoc_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SWEEP = 3'd1;
    localparam logic [2:0] ST_B_W0  = 3'd2;
    localparam logic [2:0] ST_B_R0  = 3'd3;
    localparam logic [2:0] ST_B_W1  = 3'd4;
    localparam logic [2:0] ST_B_R1  = 3'd5;

    // Single-bit fill values, replicated to the tag width by users.
    localparam logic BIST_PAT0 = 1'b0;
    localparam logic BIST_PAT1 = 1'b1;

    // Phase following a completed BIST pass; the last pass hands over to a
    // sweep so the array is left invalid.
    function automatic logic [2:0] bist_next(input logic [2:0] st);
        logic [2:0] nxt;
        nxt = ST_IDLE;
        case (st)
            ST_B_W0: nxt = ST_B_R0;
            ST_B_R0: nxt = ST_B_W1;
            ST_B_W1: nxt = ST_B_R1;
            ST_B_R1: nxt = ST_SWEEP;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/itag_assoc_ctl.sv
// Maintenance controller: invalidate sweep and march self-test sequencing.
// Latency: busy and strobes follow a start pulse by one cycle.
// Backpressure: none; start pulses outside IDLE/SWEEP are ignored.
module itag_assoc_ctl
    import itag_assoc_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 64,
    parameter  int TAG_W = 18,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS),
    localparam int ENT_W = IDX_W + WAY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inval_all,
    input  logic             bist_start,
    input  logic [TAG_W-1:0] bist_rdat,
    output logic             busy,
    output logic             sweep_we,
    output logic [IDX_W-1:0] sweep_idx,
    output logic             bist_we,
    output logic [IDX_W-1:0] bist_idx,
    output logic [WAY_W-1:0] bist_way,
    output logic [TAG_W-1:0] bist_wdat,
    output logic             test_err_l
);

    logic [2:0]       state_q;
    logic [ENT_W-1:0] cnt_q;
    logic             err_l_q;
    logic             last_set;
    logic             last_ent;
    logic             start_ok;
    logic             bist_chk;
    logic [TAG_W-1:0] bist_exp;

    assign last_set  = (cnt_q[IDX_W-1:0] == IDX_W'(SETS - 1));
    assign last_ent  = &cnt_q;
    assign start_ok  = (state_q == ST_IDLE) || (state_q == ST_SWEEP);
    assign bist_chk  = (state_q == ST_B_R0) || (state_q == ST_B_R1);
    assign bist_exp  = (state_q == ST_B_R1) ? {TAG_W{BIST_PAT1}} : {TAG_W{BIST_PAT0}};

    assign busy       = (state_q != ST_IDLE);
    assign sweep_we   = (state_q == ST_SWEEP);
    assign sweep_idx  = cnt_q[IDX_W-1:0];
    // Entry counter packs way in the low bits so consecutive entries walk ways first.
    assign bist_way   = cnt_q[WAY_W-1:0];
    assign bist_idx   = cnt_q[WAY_W +: IDX_W];
    assign bist_we    = (state_q == ST_B_W0) || (state_q == ST_B_W1);
    assign bist_wdat  = (state_q == ST_B_W1) ? {TAG_W{BIST_PAT1}} : {TAG_W{BIST_PAT0}};
    assign test_err_l = err_l_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_l_q <= 1'b1;
        end else if (bist_start && start_ok) begin
            state_q <= ST_B_W0;
            cnt_q   <= '0;
            err_l_q <= 1'b1;
        end else begin
            if (bist_chk && (bist_rdat != bist_exp)) begin
                err_l_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (inval_all) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (inval_all) begin
                        cnt_q <= '0;
                    end else if (last_set) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ENT_W'(1);
                    end
                end
                ST_B_W0, ST_B_R0, ST_B_W1, ST_B_R1: begin
                    // All-ones counter wraps to zero as the next phase begins.
                    cnt_q <= cnt_q + ENT_W'(1);
                    if (last_ent) begin
                        state_q <= bist_next(state_q);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/itag_assoc.sv
// Set-associative instruction tag array with registered lookup and internal victim choice.
// Latency: lookup result one cycle after request; fills visible to the next cycle's lookups.
// Backpressure: none; lookups and fills arriving while busy or disabled are dropped.
module itag_assoc
    import itag_assoc_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 64,
    parameter  int TAG_W = 18,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             lookup_vld,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             fill_we,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inval_all,
    input  logic             bist_start,
    output logic             itag_vld,
    output logic             ic_hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [TAG_W-1:0] itag_dout,
    output logic             busy,
    output logic             itag_test_err_l
);

    logic [TAG_W-1:0] tag_q [SETS][WAYS];
    logic [WAYS-1:0]  vld_q [SETS];
    logic [WAY_W-1:0] rr_q  [SETS];

    logic             lookup_acc;
    logic             fill_acc;
    logic             hit_d;
    logic [WAY_W-1:0] way_d;
    logic [TAG_W-1:0] dout_d;
    logic [WAY_W-1:0] victim;
    logic             use_rr;

    logic             sweep_we;
    logic [IDX_W-1:0] sweep_idx;
    logic             bist_we;
    logic [IDX_W-1:0] bist_idx;
    logic [WAY_W-1:0] bist_way;
    logic [TAG_W-1:0] bist_wdat;
    logic [TAG_W-1:0] bist_rdat;

    assign lookup_acc = enable & lookup_vld & ~busy;
    assign fill_acc   = enable & fill_we & ~busy;
    assign bist_rdat  = tag_q[bist_idx][bist_way];

    itag_assoc_ctl #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_ctl (
        .clk        (clk),
        .reset      (reset),
        .inval_all  (inval_all),
        .bist_start (bist_start),
        .bist_rdat  (bist_rdat),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_idx  (sweep_idx),
        .bist_we    (bist_we),
        .bist_idx   (bist_idx),
        .bist_way   (bist_way),
        .bist_wdat  (bist_wdat),
        .test_err_l (itag_test_err_l)
    );

    // Scanning from the top down lets the lowest matching way win.
    always_comb begin
        hit_d  = 1'b0;
        way_d  = '0;
        dout_d = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[lookup_idx][w] && (tag_q[lookup_idx][w] == lookup_tag)) begin
                hit_d  = 1'b1;
                way_d  = WAY_W'(w);
                dout_d = tag_q[lookup_idx][w];
            end
        end
    end

    always_comb begin
        use_rr = &vld_q[fill_idx];
        victim = rr_q[fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_q[fill_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // Sweep and fill are mutually exclusive: fills are only accepted while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                vld_q[s] <= '0;
                rr_q[s]  <= '0;
            end
        end else if (sweep_we) begin
            vld_q[sweep_idx] <= '0;
            rr_q[sweep_idx]  <= '0;
        end else if (fill_acc) begin
            vld_q[fill_idx][victim] <= 1'b1;
            if (use_rr) begin
                rr_q[fill_idx] <= rr_q[fill_idx] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bist_we) begin
            tag_q[bist_idx][bist_way] <= bist_wdat;
        end else if (fill_acc) begin
            tag_q[fill_idx][victim] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            itag_vld  <= 1'b0;
            ic_hit    <= 1'b0;
            hit_way   <= '0;
            itag_dout <= '0;
        end else begin
            itag_vld <= lookup_acc;
            if (lookup_acc) begin
                ic_hit    <= hit_d;
                hit_way   <= way_d;
                itag_dout <= dout_d;
            end
        end
    end

endmodule

// File: tb/tb_itag_assoc.sv
// Scoreboard bench for itag_assoc: directed scenarios followed by random traffic
// against an array-level reference model.
module tb_itag_assoc;

    localparam int WAYS  = 2;
    localparam int SETS  = 64;
    localparam int TAG_W = 18;
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SWEEP_LEN = SETS;
    localparam int BIST_LEN  = 4 * WAYS * SETS + SETS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             lookup_vld = 1'b0;
    logic [IDX_W-1:0] lookup_idx = '0;
    logic [TAG_W-1:0] lookup_tag = '0;
    logic             fill_we = 1'b0;
    logic [IDX_W-1:0] fill_idx = '0;
    logic [TAG_W-1:0] fill_tag = '0;
    logic             inval_all = 1'b0;
    logic             bist_start = 1'b0;
    logic             itag_vld;
    logic             ic_hit;
    logic [WAY_W-1:0] hit_way;
    logic [TAG_W-1:0] itag_dout;
    logic             busy;
    logic             itag_test_err_l;

    itag_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .lookup_vld      (lookup_vld),
        .lookup_idx      (lookup_idx),
        .lookup_tag      (lookup_tag),
        .fill_we         (fill_we),
        .fill_idx        (fill_idx),
        .fill_tag        (fill_tag),
        .inval_all       (inval_all),
        .bist_start      (bist_start),
        .itag_vld        (itag_vld),
        .ic_hit          (ic_hit),
        .hit_way         (hit_way),
        .itag_dout       (itag_dout),
        .busy            (busy),
        .itag_test_err_l (itag_test_err_l)
    );

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [TAG_W-1:0] tag;
    } resp_t;

    int    checks = 0;
    int    failures = 0;
    resp_t exp_q[$];

    // Reference model: per-set lists of valid flags, tags and replacement pointers,
    // plus a count of remaining busy cycles.
    bit               m_vld [SETS][WAYS];
    logic [TAG_W-1:0] m_tag [SETS][WAYS];
    int               m_rr  [SETS];
    int               busy_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
        end
    endfunction

    function automatic resp_t m_lookup(input int idx, input logic [TAG_W-1:0] t);
        resp_t r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!r.hit && m_vld[idx][w] && m_tag[idx][w] == t) begin
                r.hit = 1'b1;
                r.way = WAY_W'(w);
                r.tag = t;
            end
        end
        return r;
    endfunction

    function automatic void m_fill(input int idx, input logic [TAG_W-1:0] t);
        int v;
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !m_vld[idx][w]) v = w;
        if (v < 0) begin
            v = m_rr[idx];
            m_rr[idx] = (m_rr[idx] + 1) % WAYS;
        end
        m_vld[idx][v] = 1'b1;
        m_tag[idx][v] = t;
    endfunction

    // One clock of stimulus; the model advances alongside the DUT.
    task automatic cyc(input bit lv, input int li, input logic [TAG_W-1:0] lt,
                       input bit fw, input int fi, input logic [TAG_W-1:0] ft,
                       input bit inv = 1'b0, input bit bs = 1'b0, input bit en = 1'b1);
        @(negedge clk);
        check("busy", 32'(busy), 32'(busy_rem > 0));
        enable     = en;
        lookup_vld = lv;
        lookup_idx = IDX_W'(li);
        lookup_tag = lt;
        fill_we    = fw;
        fill_idx   = IDX_W'(fi);
        fill_tag   = ft;
        inval_all  = inv;
        bist_start = bs;
        if (en && lv && busy_rem == 0) exp_q.push_back(m_lookup(li, lt));
        if (en && fw && busy_rem == 0) m_fill(fi, ft);
        // Starts are honoured while idle or in a sweep (including the post-BIST sweep).
        if (bs && busy_rem <= SWEEP_LEN) begin
            busy_rem = BIST_LEN;
            m_clear();
        end else if (inv && busy_rem <= SWEEP_LEN) begin
            busy_rem = SWEEP_LEN;
            m_clear();
        end else if (busy_rem > 0) begin
            busy_rem--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        lookup_vld = 1'b0;
        fill_we    = 1'b0;
        inval_all  = 1'b0;
        bist_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_clear();
        busy_rem = 0;
        check("rst_itag_vld", 32'(itag_vld), 32'd0);
        check("rst_ic_hit", 32'(ic_hit), 32'd0);
        check("rst_hit_way", 32'(hit_way), 32'd0);
        check("rst_itag_dout", 32'(itag_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_l", 32'(itag_test_err_l), 32'd1);
    endtask

    // Monitor: pops an expectation for every itag_vld, otherwise checks outputs hold.
    resp_t held = '0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            held = '0;
        end else if (itag_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_itag_vld actual=1 required=0 at %0t", $time);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("ic_hit", 32'(ic_hit), 32'(e.hit));
                check("hit_way", 32'(hit_way), 32'(e.way));
                check("itag_dout", 32'(itag_dout), 32'(e.tag));
                held = e;
            end
        end else begin
            check("hold_ic_hit", 32'(ic_hit), 32'(held.hit));
            check("hold_hit_way", 32'(hit_way), 32'(held.way));
            check("hold_itag_dout", 32'(itag_dout), 32'(held.tag));
        end
    end

    logic [TAG_W-1:0] pool [6];

    initial begin
        pool = '{18'h01234, 18'h02222, 18'h3FFFF, 18'h00000, 18'h15A5A, 18'h00ABC};
        m_clear();
        do_reset();

        cyc(1'b1, 5, 18'h1234, 1'b0, 0, '0);
        cyc(1'b0, 0, '0, 1'b1, 5, 18'h1234);
        cyc(1'b0, 0, '0, 1'b1, 5, 18'h2222);
        cyc(1'b1, 5, 18'h1234, 1'b0, 0, '0);
        cyc(1'b1, 5, 18'h2222, 1'b0, 0, '0);
        cyc(1'b0, 0, '0, 1'b1, 5, 18'h3333);
        cyc(1'b0, 0, '0, 1'b1, 5, 18'h0444);
        cyc(1'b1, 5, 18'h1234, 1'b0, 0, '0);
        cyc(1'b1, 5, 18'h3333, 1'b0, 0, '0);
        cyc(1'b1, 5, 18'h0444, 1'b0, 0, '0);
        cyc(1'b1, 9, 18'h0ABC, 1'b1, 9, 18'h0ABC);
        cyc(1'b1, 9, 18'h0ABC, 1'b0, 0, '0);
        // Disabled requests are ignored entirely.
        cyc(1'b1, 9, 18'h0ABC, 1'b1, 9, 18'h0777, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9, 18'h0777, 1'b0, 0, '0);

        for (int s = 0; s < SETS; s++) cyc(1'b0, 0, '0, 1'b1, s, TAG_W'(s + 18'h100));
        cyc(1'b1, 3, 18'h103, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < SWEEP_LEN; i++)
            cyc(1'b1, i, TAG_W'(i + 18'h100), 1'b1, i, 18'h2AAAA);
        for (int s = 0; s < SETS; s++) cyc(1'b1, s, TAG_W'(s + 18'h100), 1'b0, 0, '0);

        for (int s = 0; s < SETS; s++) cyc(1'b0, 0, '0, 1'b1, s, TAG_W'(s));
        cyc(1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 1'b1);
        idle(BIST_LEN + 2);
        check("bist_err_l", 32'(itag_test_err_l), 32'd1);
        for (int s = 0; s < SETS; s++) cyc(1'b1, s, TAG_W'(s), 1'b0, 0, '0);

        cyc(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 1'b1);
        idle(BIST_LEN + 2);
        check("bist2_err_l", 32'(itag_test_err_l), 32'd1);

        cyc(1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 1'b1);
        idle(199);
        do_reset();
        cyc(1'b1, 5, 18'h0005, 1'b0, 0, '0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3), pool[$urandom_range(0, 5)],
                $urandom_range(0, 2) == 0, $urandom_range(0, 3), pool[$urandom_range(0, 5)],
                r < 4, (r == 999) && (i < 3000), $urandom_range(0, 7) != 0);
        end
        for (int i = 0; i < BIST_LEN + 2 && busy_rem > 0; i++) idle(1);
        idle(3);
        check("bist_rand_err_l", 32'(itag_test_err_l), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
